world_map: RTL and testbench
============================

Name: world_map

Overview:
- Tile-map store for the raycaster: a 16x16 grid of wall/empty cells addressed by integer map coordinates from the DDA walker.
- Returns a combinational wall flag for the addressed cell and latches the first wall cell hit on each ray.
- Sits beside the ray calculator, which steps xPos/yPos and stops on is_wall.

Parameters:
- MAP_W, 16, grid width in cells; xPos indexes 0..MAP_W-1.
- MAP_H, 16, grid height in cells; yPos indexes 0..MAP_H-1.

Ports:
- clk, input, 1, single clock, rising edge.
- reset, input, 1, synchronous, active-high.
- xPos, input, 4, map column of the cell under test.
- yPos, input, 4, map row of the cell under test.
- setup_complete, input, 1, ray setup done; lookup results are valid only while high.
- is_new_ray, input, 1, one-cycle pulse that re-arms hit capture for the next ray.
- is_wall, output, 1, addressed cell is a wall (gated by setup_complete).
- hit_coord_x, output, 4, column of the first wall hit on the current ray.
- hit_coord_y, output, 4, row of the first wall hit on the current ray.

Behaviour:
- Map storage: MAP_W*MAP_H bits, cell(x,y)=1 means wall. Loaded with the default layout on reset and at initialisation.
- Default layout, walls at:
  - every border cell: x=0, x=15, y=0 or y=15;
  - the interior block x in {4,5}, y in {4,5};
  - the column x=10, y=3..7.
  - All other cells are empty.
- is_wall = setup_complete AND cell(xPos,yPos). Purely combinational, zero latency. It is 0 whenever setup_complete=0, and 0 while reset is high.
- Coordinates are 4-bit and always in range, so there is no out-of-bounds case. Border walls guarantee a ray terminates before its coordinates wrap.
- Internal flag hit_latched, reset 0. Capture rule, evaluated each rising edge:
  - If reset: hit_coord_x=0, hit_coord_y=0, hit_latched=0.
  - Else if is_new_ray: hit_latched<=0; hit coords hold their values.
  - Else if setup_complete AND cell(xPos,yPos) AND NOT hit_latched: hit_coord_x<=xPos, hit_coord_y<=yPos, hit_latched<=1.
  - Otherwise everything holds.
- Latency: hit_coord_* are valid one cycle after the first cycle with is_wall=1.
- Later wall cells on the same ray do not overwrite the capture.
- If is_new_ray and a hit occur in the same cycle, is_new_ray wins and nothing is captured.
- If reset is asserted mid-ray, all state and outputs clear on that edge, and the map reloads its default layout.
- No output depends on is_new_ray combinationally.

Optional Feature:
- Macro: WORLD_MAP_WRITE_EN.
- When defined, add three ports:
  - wr_en, input, 1;
  - wr_addr, input, 8, {y[3:0],x[3:0]};
  - wr_data, input, 1.
- On a rising edge with wr_en=1 and reset=0, cell(wr_addr) <= wr_data.
- is_wall reflects the new value from the next cycle onward.
- reset still restores the default layout and takes priority over writes.
- When not defined, the map is read-only after reset and these ports do not exist.

Test Plan:
- Reset then lookup: reset=1 for one cycle, then setup_complete=1, xPos=0, yPos=7 -> is_wall=1; xPos=3, yPos=3 -> is_wall=0; hit_coord_x=0, hit_coord_y=0 immediately after reset.
- Gating: setup_complete=0 at xPos=4, yPos=4 -> is_wall=0; raise setup_complete -> is_wall=1 in the same cycle.
- First-hit capture:
  - Pulse is_new_ray, then walk (2,5),(3,5),(4,5),(5,5), one cell per cycle, with setup_complete=1.
  - is_wall rises at (4,5); next cycle hit_coord=(4,5); it stays (4,5) after (5,5).
- Re-arm: pulse is_new_ray, then present (10,6) -> hit_coord=(10,6) one cycle later. Without an is_new_ray pulse, the previous hit is retained.
- Simultaneous event: is_new_ray=1 in the same cycle as (15,2) with setup_complete=1 -> no capture. Holding (15,2) a second cycle -> hit_coord=(15,2).
- WORLD_MAP_WRITE_EN:
  - Write wr_addr=8'h33, wr_data=1 -> next cycle (3,3) reads is_wall=1.
  - Write wr_addr=8'h00, wr_data=0 -> (0,0) reads 0.
  - Reset -> (3,3)=0 and (0,0)=1 again.

Source files
------------

// File: rtl/world_map.sv
// ---------------------------------------------------------------------------
// world_map
//   Tile-map store for the raycaster. Holds a MAP_W x MAP_H grid of wall/empty
//   cells, answers "is this cell a wall?" combinationally for the DDA walker,
//   and latches the first wall cell hit on each ray.
//
//   Optional feature macro: WORLD_MAP_WRITE_EN
//     When defined, the map becomes writable through wr_en/wr_addr/wr_data.
//     When undefined, the map is the fixed default layout.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high
//   xPos, yPos     in   4-bit map column / row of the cell under test
//   setup_complete in   lookups are only meaningful while high
//   is_new_ray     in   one-cycle pulse, re-arms hit capture
//   wr_en          in   (WORLD_MAP_WRITE_EN only) write strobe
//   wr_addr        in   (WORLD_MAP_WRITE_EN only) {y[3:0], x[3:0]}
//   wr_data        in   (WORLD_MAP_WRITE_EN only) 1 = wall
//   is_wall        out  addressed cell is a wall (combinational, gated)
//   hit_coord_x/y  out  first wall cell hit on the current ray
// ---------------------------------------------------------------------------
module world_map #(
    parameter int MAP_W = 16,   // xPos is 4 bits wide, so the grid stays 16x16
    parameter int MAP_H = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] xPos,
    input  logic [3:0] yPos,
    input  logic       setup_complete,
    input  logic       is_new_ray,
`ifdef WORLD_MAP_WRITE_EN
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic       wr_data,
`endif
    output logic       is_wall,
    output logic [3:0] hit_coord_x,
    output logic [3:0] hit_coord_y
);

    localparam int CELLS = MAP_W * MAP_H;
    localparam int IDX_W = $clog2(CELLS);

    // Cell (x,y) lives at bit y*MAP_W + x, so {yPos,xPos} is the bit index.
    function automatic logic [CELLS-1:0] default_map();
        logic [CELLS-1:0] m;
        m = '0;
        for (int y = 0; y < MAP_H; y++) begin
            for (int x = 0; x < MAP_W; x++) begin
                if (x == 0 || x == MAP_W - 1 || y == 0 || y == MAP_H - 1)
                    m[IDX_W'(y * MAP_W + x)] = 1'b1;
                if ((x == 4 || x == 5) && (y == 4 || y == 5))
                    m[IDX_W'(y * MAP_W + x)] = 1'b1;
                if (x == 10 && y >= 3 && y <= 7)
                    m[IDX_W'(y * MAP_W + x)] = 1'b1;
            end
        end
        return m;
    endfunction

    localparam logic [CELLS-1:0] DEFAULT_MAP = default_map();

    logic [CELLS-1:0] map_w;
    logic [IDX_W-1:0] rd_idx;
    logic             cell_rd;
    logic             hit_now;

`ifdef WORLD_MAP_WRITE_EN
    logic [CELLS-1:0] map_q, map_d;

    always_comb begin
        map_d = map_q;
        if (wr_en)
            map_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset)
            map_q <= DEFAULT_MAP;
        else
            map_q <= map_d;
    end

    assign map_w = map_q;
`else
    // Read-only build: the layout is a constant, always equal to its reset value.
    assign map_w = DEFAULT_MAP;
`endif

    assign rd_idx  = {yPos, xPos};
    assign cell_rd = map_w[rd_idx];
    // Reset also masks the lookup so the walker never sees a stale wall.
    assign is_wall = setup_complete & cell_rd & ~reset;

    // -----------------------------------------------------------------------
    // First-hit capture
    // -----------------------------------------------------------------------
    logic       hit_latched_q, hit_latched_d;
    logic [3:0] hit_x_q, hit_x_d;
    logic [3:0] hit_y_q, hit_y_d;

    assign hit_now = setup_complete & cell_rd;

    always_comb begin
        hit_latched_d = hit_latched_q;
        hit_x_d       = hit_x_q;
        hit_y_d       = hit_y_q;
        // A new-ray pulse wins over a same-cycle hit; coords are kept.
        if (is_new_ray) begin
            hit_latched_d = 1'b0;
        end else if (hit_now && !hit_latched_q) begin
            hit_latched_d = 1'b1;
            hit_x_d       = xPos;
            hit_y_d       = yPos;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_latched_q <= 1'b0;
            hit_x_q       <= '0;
            hit_y_q       <= '0;
        end else begin
            hit_latched_q <= hit_latched_d;
            hit_x_q       <= hit_x_d;
            hit_y_q       <= hit_y_d;
        end
    end

    assign hit_coord_x = hit_x_q;
    assign hit_coord_y = hit_y_q;

endmodule

// File: tb/tb_world_map.sv
module tb_world_map;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] xPos = '0;
    logic [3:0] yPos = '0;
    logic       setup_complete = 1'b0;
    logic       is_new_ray = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_addr = '0;
    logic       wr_data = 1'b0;
    logic       is_wall;
    logic [3:0] hit_coord_x;
    logic [3:0] hit_coord_y;

    world_map dut (
        .clk(clk),
        .reset(reset),
        .xPos(xPos),
        .yPos(yPos),
        .setup_complete(setup_complete),
        .is_new_ray(is_new_ray),
`ifdef WORLD_MAP_WRITE_EN
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
`endif
        .is_wall(is_wall),
        .hit_coord_x(hit_coord_x),
        .hit_coord_y(hit_coord_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wall;
        logic [3:0] hx;
        logic [3:0] hy;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a 2-D wall array built from the layout rules.
    bit         walls [16][16];   // [x][y]
    bit         m_latched;
    logic [3:0] m_hx, m_hy;

    function automatic void load_default();
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                walls[x][y] = (x == 0 || x == 15 || y == 0 || y == 15) ||
                              (x >= 4 && x <= 5 && y >= 4 && y <= 5) ||
                              (x == 10 && y >= 3 && y <= 7);
    endfunction

    // Advance the model across one rising edge using the inputs the DUT sampled.
    function automatic void model_edge();
        bit hit;
        if (reset) begin
            m_latched = 0;
            m_hx = '0;
            m_hy = '0;
            load_default();
        end else begin
            hit = setup_complete && walls[xPos][yPos];
            if (is_new_ray)
                m_latched = 0;
            else if (hit && !m_latched) begin
                m_latched = 1;
                m_hx = xPos;
                m_hy = yPos;
            end
`ifdef WORLD_MAP_WRITE_EN
            if (wr_en)
                walls[wr_addr[3:0]][wr_addr[7:4]] = wr_data;
`endif
        end
    endfunction

    task automatic drive(input logic r, input logic s, input logic n,
                         input logic [3:0] x, input logic [3:0] y, input string tag,
                         input logic we = 1'b0, input logic [7:0] wa = 8'h00,
                         input logic wd = 1'b0);
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        reset = r; setup_complete = s; is_new_ray = n; xPos = x; yPos = y;
        wr_en = we; wr_addr = wa; wr_data = wd;
        e.wall = s && !r && walls[x][y];
        e.hx   = m_hx;
        e.hy   = m_hy;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // Monitor: compares whatever the DUT presents mid-cycle against the queue.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (is_wall !== e.wall || hit_coord_x !== e.hx || hit_coord_y !== e.hy) begin
                errors++;
                $display("FAIL %s: got is_wall=%b hit=(%0d,%0d) expected is_wall=%b hit=(%0d,%0d)",
                         e.tag, is_wall, hit_coord_x, hit_coord_y, e.wall, e.hx, e.hy);
            end
        end
    end

    initial begin
        load_default();
        m_latched = 0; m_hx = '0; m_hy = '0;

        drive(1, 1, 0, 0, 0, "wall_masked_in_reset");
        drive(0, 1, 0, 0, 7, "border_wall");
        drive(0, 1, 0, 3, 3, "empty_cell");
        drive(0, 0, 0, 4, 4, "gated_off");
        drive(0, 1, 0, 4, 4, "gated_on");
        // first-hit capture along a row
        drive(0, 1, 1, 2, 5, "new_ray_pulse");
        drive(0, 1, 0, 3, 5, "walk_3_5");
        drive(0, 1, 0, 4, 5, "walk_4_5_wall");
        drive(0, 1, 0, 5, 5, "walk_5_5_captured");
        drive(0, 1, 0, 6, 5, "no_overwrite");
        // re-arm
        drive(0, 1, 1, 7, 7, "rearm_pulse");
        drive(0, 1, 0, 10, 6, "column_wall");
        drive(0, 1, 0, 7, 7, "captured_10_6");
        drive(0, 1, 0, 0, 3, "retain_without_rearm");
        drive(0, 1, 0, 7, 7, "still_10_6");
        // new ray and hit in the same cycle
        drive(0, 1, 1, 15, 2, "simultaneous");
        drive(0, 1, 0, 15, 2, "no_capture_yet");
        drive(0, 1, 0, 7, 7, "captured_15_2");
        // reset mid-ray
        drive(1, 1, 0, 15, 8, "reset_mid_ray");
        drive(0, 1, 0, 7, 7, "after_reset_clear");
`ifdef WORLD_MAP_WRITE_EN
        drive(0, 1, 1, 7, 7, "wr_33", 1'b1, 8'h33, 1'b1);
        drive(0, 1, 0, 3, 3, "read_33_wall");
        drive(0, 1, 1, 7, 7, "wr_00", 1'b1, 8'h00, 1'b0);
        drive(0, 1, 0, 0, 0, "read_00_empty");
        drive(1, 1, 0, 7, 7, "reset_restore", 1'b1, 8'h77, 1'b1);
        drive(0, 1, 0, 3, 3, "restored_33");
        drive(0, 1, 0, 0, 0, "restored_00");
        drive(0, 1, 0, 7, 7, "reset_beats_write");
`endif

        for (int i = 0; i < 600; i++) begin
            logic r, s, n, we, wd;
            logic [3:0] x, y;
            logic [7:0] wa;
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 85);
            n  = ($urandom_range(0, 99) < 12);
            x  = 4'($urandom_range(0, 15));
            y  = 4'($urandom_range(0, 15));
            we = ($urandom_range(0, 99) < 10);
            wa = 8'($urandom_range(0, 255));
            wd = 1'($urandom_range(0, 1));
            drive(r, s, n, x, y, "random", we, wa, wd);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
